// File: rtl/dmem_resp_pkg.sv
// Shared types and widths for the data-memory responder.
// The optional error check is compiled in with DMEM_RESP_ERR_EN.
package dmem_resp_pkg;

  localparam int DATA_W     = 32;
  localparam int BE_W       = 4;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Replace the byte lanes selected by be with the matching lanes of new_word.
  function automatic logic [DATA_W-1:0] be_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < BE_W; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_resp_array.sv
// Word storage for the responder: synchronous byte-enabled write, combinational read.
// Contents are intentionally not reset.
module dmem_resp_array
  import dmem_resp_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Byte-masked store into the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= be_merge(mem_r[addr], wdata, be);
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, waits WAIT_STATES cycles, performs it, holds the response.
// Define DMEM_RESP_ERR_EN to flag misaligned / out-of-range addresses on rsp_err.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  state_e                  state_r;
  state_e                  state_nxt_s;
  logic [WAIT_CNT_W-1:0]   cnt_r;
  logic                    write_r;
  logic [31:0]             addr_r;
  logic [DATA_W-1:0]       wdata_r;
  logic [BE_W-1:0]         be_r;
  logic                    req_ready_r;
  logic                    rsp_valid_r;
  logic [DATA_W-1:0]       rsp_rdata_r;
  logic                    rsp_err_r;
  logic                    accept_s;
  logic                    access_s;
  logic                    err_s;
  logic                    we_s;
  logic [DATA_W-1:0]       rd_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and handshake strobes.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    access_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready_r) begin
          accept_s    = 1'b1;
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == {WAIT_CNT_W{1'b0}}) begin
          access_s    = 1'b1;
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

`ifdef DMEM_RESP_ERR_EN
  // Misaligned or beyond-storage addresses are rejected.
  always_comb begin
    err_s = (addr_r[1:0] != 2'b00) || (|addr_r[31:ADDR_W+2]);
  end
`else
  logic unused_addr_s;

  // No checking: upper and byte-offset address bits simply alias.
  always_comb begin
    err_s         = 1'b0;
    unused_addr_s = ^{addr_r[31:ADDR_W+2], addr_r[1:0]};
  end
`endif

  assign we_s = access_s && write_r && !err_s;

  dmem_resp_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (we_s),
    .addr  (addr_r[ADDR_W+1:2]),
    .wdata (wdata_r),
    .be    (be_r),
    .rdata (rd_s)
  );

  // Request latch and wait counter; req_* are only sampled in the accept cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= {WAIT_CNT_W{1'b0}};
      write_r <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= {DATA_W{1'b0}};
      be_r    <= {BE_W{1'b0}};
    end else if (accept_s) begin
      cnt_r   <= WAIT_CNT_W'(WAIT_STATES);
      write_r <= req_write;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
      be_r    <= req_be;
    end else if ((state_r == WAIT) && (cnt_r != {WAIT_CNT_W{1'b0}})) begin
      cnt_r   <= cnt_r - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Registered handshake outputs track the next state so they change with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      req_ready_r <= (state_nxt_s == IDLE);
      rsp_valid_r <= (state_nxt_s == RESP);
    end
  end

  // Response payload captured once at the access edge and held through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end else if (access_s) begin
      rsp_rdata_r <= (write_r || err_s) ? {DATA_W{1'b0}} : rd_s;
      rsp_err_r   <= err_s;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder; expectations come from a bench-side word model.
// Honours DMEM_RESP_ERR_EN when the build defines it.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int WS = 2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int          n_vec  = 0;
  int          n_miss = 0;
  exp_t        sb_q[$];
  logic [31:0] model_mem [256];

  dmem_responder #(
    .ADDR_W      (8),
    .WAIT_STATES (WS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_err(input logic [31:0] addr);
`ifdef DMEM_RESP_ERR_EN
    return (addr[1:0] != 2'b00) || (addr[31:10] != 22'd0);
`else
    return 1'b0;
`endif
  endfunction

  // One full transaction: accept, push expectation, await response, hold, handshake.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold);
    int          n;
    exp_t        e;
    exp_t        got;
    logic [7:0]  idx;
    logic [31:0] held;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready) check_val("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    tick();
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);

    idx   = addr[9:2];
    e.err = exp_err(addr);
    if (wr) begin
      if (!e.err) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
      end
      e.rdata = 32'd0;
    end else begin
      e.rdata = e.err ? 32'd0 : model_mem[idx];
    end
    sb_q.push_back(e);

    check_val("ready_after_accept", {31'd0, req_ready}, 32'd0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check_val("latency", 32'(n), 32'(WS + 1));
    got = sb_q.pop_front();
    check_val("rsp_rdata", rsp_rdata, got.rdata);
    check_val("rsp_err", {31'd0, rsp_err}, {31'd0, got.err});

    held = rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      tick();
      check_val("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check_val("hold_rdata", rsp_rdata, held);
      check_val("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_val("valid_after_hs", {31'd0, rsp_valid}, 32'd0);
    check_val("ready_after_hs", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_be    = 4'd0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    check_val("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_val("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    #4 rst = 1'b0;
    tick();
    check_val("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Give the low 32 words known contents before any load.
    for (int i = 0; i < 32; i++) begin
      do_req(1'b1, 32'(i * 4), 32'h5A00_0000 | 32'(i * 32'h0001_0101), 4'hF, 0);
    end

    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
    do_req(1'b0, 32'h10, 32'd0, 4'h0, 0);

    do_req(1'b1, 32'h14, 32'hAABB_CCDD, 4'hF, 0);
    do_req(1'b1, 32'h14, 32'h1122_3344, 4'b0101, 0);
    do_req(1'b0, 32'h14, 32'd0, 4'h0, 5);

    do_req(1'b1, 32'h18, 32'hFFFF_FFFF, 4'h0, 0);
    do_req(1'b0, 32'h18, 32'd0, 4'h0, 1);

    // Reset during WAIT of a store drops the store.
    do_req(1'b1, 32'h20, 32'h0, 4'hF, 0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h1234_5678;
    req_be    = 4'hF;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check_val("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    check_val("midrst_rsp_rdata", rsp_rdata, 32'd0);
    #3 rst = 1'b0;
    tick();
    check_val("ready_after_midrst", {31'd0, req_ready}, 32'd1);
    do_req(1'b0, 32'h20, 32'd0, 4'h0, 0);

    // Addresses that alias (or error when checking is built in).
    do_req(1'b0, 32'h13, 32'd0, 4'h0, 0);
    do_req(1'b1, 32'h400, 32'hCAFE_F00D, 4'hF, 0);
    do_req(1'b0, 32'h0, 32'd0, 4'h0, 0);
    do_req(1'b1, 32'h8000_0447, 32'h0BAD_CAFE, 4'b1010, 2);
    do_req(1'b0, 32'h44, 32'd0, 4'h0, 0);

    for (int k = 0; k < 16; k++) begin
      logic [31:0] a;
      a = {($urandom_range(0, 3) == 0) ? 22'($urandom) : 22'd0, 5'($urandom), 2'd0, 3'd0};
      a[6:2] = 5'($urandom);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
      do_req(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
